// File: rtl/alu_seq_if.sv
// Request/result bundle between a requester and the alu_seq sequential ALU.
// The requester drives the operands and start; the ALU returns result, flags and status.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       OP;
   logic [WIDTH-1:0] R;
   logic             CF;
   logic             ZF;
   logic             busy;
   logic             done;

   modport master (output start, A, B, OP, input R, CF, ZF, busy, done);
   modport slave  (input start, A, B, OP, output R, CF, ZF, busy, done);
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/NAND, bit-serial SHL and an optional shift-add MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise OP=100 is treated as illegal.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   alu_seq_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     r_q, r_d;
   logic                 cf_q, cf_d;
   logic                 zf_q, zf_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     sh_q, sh_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     shamt;
   logic                 fin;
   logic [WIDTH-1:0]     res;
   logic                 res_cf;
`ifdef ALU_SEQ_MUL_EN
   logic                 is_mul_q, is_mul_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod;
`endif

   assign shamt    = CNT_W'(32'(bus.B) % 32'(WIDTH));
   assign bus.R    = r_q;
   assign bus.CF   = cf_q;
   assign bus.ZF   = zf_q;
   assign bus.done = done_q;
   assign bus.busy = (state_q == EXEC);

   // Next-state and datapath: any path that sets fin publishes res/res_cf and returns to IDLE.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cf_d    = cf_q;
      zf_d    = zf_q;
      done_d  = 1'b0;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      fin     = 1'b0;
      res     = '0;
      res_cf  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      is_mul_d = is_mul_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod     = '0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.OP)
                  3'b000: begin
                     {res_cf, res} = {1'b0, bus.A} + {1'b0, bus.B};
                     fin = 1'b1;
                  end
                  3'b001: begin
                     {res_cf, res} = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
                     fin = 1'b1;
                  end
                  3'b010: begin
                     // Shifts of 0 or 1 finish on the accept edge; longer ones do one shift per edge.
                     if (shamt == '0) begin
                        res = bus.A;
                        fin = 1'b1;
                     end else if (shamt == CNT_W'(1)) begin
                        res    = bus.A << 1;
                        res_cf = bus.A[WIDTH-1];
                        fin    = 1'b1;
                     end else begin
                        sh_d    = bus.A << 1;
                        cnt_d   = shamt - CNT_W'(1);
                        state_d = EXEC;
`ifdef ALU_SEQ_MUL_EN
                        is_mul_d = 1'b0;
`endif
                     end
                  end
                  3'b011: begin
                     res = ~(bus.A & bus.B);
                     fin = 1'b1;
                  end
`ifdef ALU_SEQ_MUL_EN
                  3'b100: begin
                     acc_d    = bus.B[0] ? {{WIDTH{1'b0}}, bus.A} : '0;
                     mcand_d  = {{WIDTH{1'b0}}, bus.A} << 1;
                     mplier_d = bus.B >> 1;
                     cnt_d    = CNT_W'(WIDTH - 1);
                     is_mul_d = 1'b1;
                     state_d  = EXEC;
                  end
`endif
                  default: fin = 1'b1;
               endcase
            end
         end
         EXEC: begin
            res    = sh_q << 1;
            res_cf = sh_q[WIDTH-1];
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            fin    = (cnt_q == CNT_W'(1));
`ifdef ALU_SEQ_MUL_EN
            if (is_mul_q) begin
               prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
               acc_d    = prod;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               res      = prod[WIDTH-1:0];
               res_cf   = |prod[2*WIDTH-1:WIDTH];
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (fin) begin
         r_d     = res;
         cf_d    = res_cf;
         zf_d    = (res == '0);
         done_d  = 1'b1;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
         done_q  <= 1'b0;
         sh_q    <= '0;
         cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
         is_mul_q <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cf_q    <= cf_d;
         zf_q    <= zf_d;
         done_q  <= done_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
         is_mul_q <= is_mul_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`endif
      end
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; accepted on an edge where start=1 and state=IDLE.
REQ-005 A, B  input  WIDTH each  operands, sampled only on accept.
REQ-006 OP  input  3  opcode, sampled on accept: 000 ADD, 001 SUB, 010 SHL, 011 NAND, 100 MUL, 101-111 illegal.
REQ-007 R  output  WIDTH  registered result, held until the next completion.
REQ-008 CF  output  1  registered carry flag, held with R.
REQ-009 ZF  output  1  registered zero flag, 1 iff R==0, held with R.
REQ-010 busy  output  1  high while state=EXEC.
REQ-011 done  output  1  one-cycle pulse in the cycle R/CF/ZF first show a new result.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and EXEC; busy=(state==EXEC).
REQ-013 start while busy=1 SHALL be ignored, with no effect on operands, outputs or state.
REQ-014 start in the cycle done=1 SHALL be accepted (state is IDLE).
REQ-015 Latency L = edges from accept edge to the edge raising done, inclusive: ADD, SUB, NAND, illegal, SHL by 0 -> L=1, staying in IDLE.
REQ-016 ADD: R=(A+B) mod 2^WIDTH; CF=carry out of bit WIDTH-1.
REQ-017 SUB: R=(A-B) mod 2^WIDTH computed as A+~B+1; CF=carry out (1 = no borrow, A>=B).
REQ-018 NAND: R=~(A&B) bitwise; CF=0.
REQ-019 SHL: count n=B mod WIDTH; R shifts left one bit per EXEC cycle, L=n for n>=1; CF=last bit shifted out (0 if n=0); zero fill.
REQ-020 MUL: iterative shift-add, one multiplier bit per EXEC cycle, L=WIDTH; R=low WIDTH bits of A*B; CF=1 iff high WIDTH bits nonzero.
REQ-021 Illegal OP: R=0, CF=0, ZF=1, done pulses with L=1.
REQ-022 R, CF, ZF SHALL not change during EXEC; they update only on the edge raising done.
REQ-023 EXEC returns to IDLE on the edge raising done.
REQ-024 Inputs A, B, OP changing during EXEC SHALL not affect the result in progress.

Reset
REQ-025 On rst=1 at an edge: state=IDLE, R=0, CF=0, ZF=0, busy=0, done=0; internal counters/accumulators cleared.
REQ-026 rst SHALL take priority over start; start with rst=1 is not accepted.
REQ-027 Reset mid-EXEC SHALL abort the operation; no done pulse is produced for it.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined: OP=100 performs MUL per REQ-020.
REQ-029 Macro ALU_SEQ_MUL_EN undefined: multiplier logic absent; OP=100 handled as illegal per REQ-021.

Verification (WIDTH=8)
REQ-030 ADD A=0xF0 B=0x20 -> one edge later done=1, R=0x10, CF=1, ZF=0, busy never high.
REQ-031 SUB A=0x05 B=0x05 -> L=1, R=0x00, CF=1, ZF=1; SUB A=0x03 B=0x05 -> R=0xFE, CF=0.
REQ-032 SHL A=0x81 B=0x0B (n=3) -> busy high 2 cycles, done at L=3, R=0x08, CF=0; start pulsed while busy is ignored.
REQ-033 MUL A=0x10 B=0x11 (MUL_EN defined) -> L=8, R=0x10, CF=1; undefined -> L=1, R=0x00, CF=0, ZF=1.
REQ-034 MUL started, rst asserted at 4th EXEC cycle -> next cycle all outputs 0, state IDLE, no done pulse; following ADD 0x01+0x01 -> R=0x02.
REQ-035 Back-to-back: start held high across NAND A=0xFF B=0x0F then ADD -> done in consecutive cycles, R=0xF0 then ADD result.
